// File: rtl/cv32e40p_rvfi_pkg.sv
// Shared types for the RVFI retirement monitor: FSM states, error codes,
// RVFI trap/intr field layouts and the error-log entry format.
package cv32e40p_rvfi_pkg;

  localparam int unsigned RVFI_MON_ERR_W  = 5;
  localparam int unsigned RVFI_MON_CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    HALTED = 2'd2
  } rvfi_mon_state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_ORDER = 3'd1,
    ERR_PC    = 3'd2,
    ERR_INTR  = 3'd3,
    ERR_TRAP  = 3'd4,
    ERR_HALT  = 3'd5
  } rvfi_mon_err_e;

  typedef struct packed {
    logic [1:0] cause_type;
    logic [2:0] debug_cause;
    logic [5:0] exception_cause;
    logic       debug;
    logic       exception;
    logic       trap;
  } rvfi_trap_t;

  typedef struct packed {
    logic [10:0] cause;
    logic        interrupt;
    logic        exception;
    logic        intr;
  } rvfi_intr_t;

  typedef struct packed {
    logic [RVFI_MON_CODE_W-1:0] code;
    logic [31:0]                order;
    logic [31:0]                pc;
  } rvfi_mon_log_t;

  localparam int unsigned RVFI_MON_LOG_W = $bits(rvfi_mon_log_t);

  // Code of the lowest-numbered error flagged; bit i corresponds to code i+1.
  function automatic logic [RVFI_MON_CODE_W-1:0] lowest_err_code(input logic [RVFI_MON_ERR_W-1:0] err);
    logic [RVFI_MON_CODE_W-1:0] code;
    code = '0;
    for (int i = RVFI_MON_ERR_W - 1; i >= 0; i--) begin
      if (err[i]) code = RVFI_MON_CODE_W'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/cv32e40p_rvfi_mon_fifo.sv
// Synchronous-reset FIFO for monitor error entries; reads as zero when empty.
module cv32e40p_rvfi_mon_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt == CNT_W'(DEPTH));
  assign empty_o = (cnt == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/cv32e40p_rvfi_monitor.sv
// RVFI retirement monitor: checks order/PC continuity, trap/intr encoding and
// post-halt retirement; counts events and logs errors into a drainable FIFO.
module cv32e40p_rvfi_monitor
  import cv32e40p_rvfi_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rvfi_valid_i,
  input  logic [63:0]               rvfi_order_i,
  input  logic [31:0]               rvfi_pc_rdata_i,
  input  logic [31:0]               rvfi_pc_wdata_i,
  input  rvfi_trap_t                rvfi_trap_i,
  input  rvfi_intr_t                rvfi_intr_i,
  input  logic                      rvfi_halt_i,
  output logic                      log_valid_o,
  input  logic                      log_ready_i,
  output rvfi_mon_log_t             log_entry_o,
  output logic [RVFI_MON_ERR_W-1:0] err_mask_o,
  output logic                      log_ovfl_o,
  output logic [63:0]               retire_cnt_o,
  output logic [31:0]               trap_cnt_o,
  output logic [31:0]               intr_cnt_o
);

  rvfi_mon_state_e           state;
  logic [63:0]               last_order;
  logic [31:0]               last_pc;
  logic [RVFI_MON_ERR_W-1:0] err_c;
  logic                      log_push_q;
  rvfi_mon_log_t             log_data_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      log_pop;
  logic                      unused_fields;

  assign unused_fields = ^{rvfi_trap_i.cause_type, rvfi_trap_i.debug_cause,
                           rvfi_trap_i.exception_cause, rvfi_intr_i.cause};

  // Per-retirement checks; IDLE only seeds history so continuity checks are skipped there.
  always_comb begin
    err_c = '0;
    if (rvfi_valid_i) begin
      err_c[0] = (state == TRACK) && (rvfi_order_i != last_order + 64'd1);
      err_c[1] = (state == TRACK) && !rvfi_intr_i.intr && (rvfi_pc_rdata_i != last_pc);
      err_c[2] = rvfi_intr_i.intr && (rvfi_intr_i.exception == rvfi_intr_i.interrupt);
      err_c[3] = rvfi_trap_i.trap ? !(rvfi_trap_i.exception | rvfi_trap_i.debug)
                                  :  (rvfi_trap_i.exception | rvfi_trap_i.debug);
      err_c[4] = (state == HALTED);
    end
  end

  assign log_valid_o = ~fifo_empty;
  assign log_pop     = log_valid_o & log_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      last_order   <= '0;
      last_pc      <= '0;
      err_mask_o   <= '0;
      log_ovfl_o   <= 1'b0;
      retire_cnt_o <= '0;
      trap_cnt_o   <= '0;
      intr_cnt_o   <= '0;
      log_push_q   <= 1'b0;
      log_data_q   <= '0;
    end else begin
      log_push_q <= 1'b0;
      if (log_push_q && fifo_full && !log_pop) log_ovfl_o <= 1'b1;
      if (rvfi_valid_i) begin
        case (state)
          IDLE:    state <= rvfi_halt_i ? HALTED : TRACK;
          TRACK:   if (rvfi_halt_i) state <= HALTED;
          default: state <= HALTED;
        endcase
        last_order   <= rvfi_order_i;
        last_pc      <= rvfi_pc_wdata_i;
        retire_cnt_o <= retire_cnt_o + 64'd1;
        if (rvfi_trap_i.trap && (trap_cnt_o != '1)) trap_cnt_o <= trap_cnt_o + 32'd1;
        if (rvfi_intr_i.intr && (intr_cnt_o != '1)) intr_cnt_o <= intr_cnt_o + 32'd1;
        err_mask_o <= err_mask_o | err_c;
        log_push_q <= |err_c;
        log_data_q <= '{code:  lowest_err_code(err_c),
                        order: rvfi_order_i[31:0],
                        pc:    rvfi_pc_rdata_i};
      end
    end
  end

  cv32e40p_rvfi_mon_fifo #(
    .WIDTH (RVFI_MON_LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (log_push_q),
    .data_i  (log_data_q),
    .pop_i   (log_pop),
    .data_o  (log_entry_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_cv32e40p_rvfi_monitor.sv
// Directed bench for cv32e40p_rvfi_monitor: one task per scenario with inline checks.
module tb_cv32e40p_rvfi_monitor;
  import cv32e40p_rvfi_pkg::*;

  localparam logic [13:0] TRAP_BARE = 14'h0001;  // trap=1, exception=debug=0
  localparam logic [13:0] INTR_EXC  = 14'h0003;  // intr=1, exception=1, interrupt=0

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rvfi_valid = 1'b0;
  logic [63:0]   rvfi_order = '0;
  logic [31:0]   pc_rdata = '0;
  logic [31:0]   pc_wdata = '0;
  rvfi_trap_t    rvfi_trap = '0;
  rvfi_intr_t    rvfi_intr = '0;
  logic          rvfi_halt = 1'b0;
  logic          log_valid;
  logic          log_ready = 1'b0;
  rvfi_mon_log_t log_entry;
  logic [4:0]    err_mask;
  logic          log_ovfl;
  logic [63:0]   retire_cnt;
  logic [31:0]   trap_cnt;
  logic [31:0]   intr_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cv32e40p_rvfi_monitor #(.LOG_DEPTH(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rvfi_valid_i    (rvfi_valid),
    .rvfi_order_i    (rvfi_order),
    .rvfi_pc_rdata_i (pc_rdata),
    .rvfi_pc_wdata_i (pc_wdata),
    .rvfi_trap_i     (rvfi_trap),
    .rvfi_intr_i     (rvfi_intr),
    .rvfi_halt_i     (rvfi_halt),
    .log_valid_o     (log_valid),
    .log_ready_i     (log_ready),
    .log_entry_o     (log_entry),
    .err_mask_o      (err_mask),
    .log_ovfl_o      (log_ovfl),
    .retire_cnt_o    (retire_cnt),
    .trap_cnt_o      (trap_cnt),
    .intr_cnt_o      (intr_cnt)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [63:0] o, input logic [31:0] pr, input logic [31:0] pw,
                        input logic [13:0] tr, input logic [13:0] in, input logic h);
    rvfi_valid = 1'b1; rvfi_order = o; pc_rdata = pr; pc_wdata = pw;
    rvfi_trap = tr; rvfi_intr = in; rvfi_halt = h;
    cyc(1);
    rvfi_valid = 1'b0; rvfi_trap = '0; rvfi_intr = '0; rvfi_halt = 1'b0;
  endtask

  task automatic do_reset();
    log_ready = 1'b0; rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic pop_one();
    log_ready = 1'b1;
    cyc(1);
    log_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (log_valid !== 1'b0) $display("FAIL rst_log_valid: got %b want 0", log_valid); else passed++;
    total++; if (err_mask !== 5'h00) $display("FAIL rst_err_mask: got %b want 00000", err_mask); else passed++;
    total++; if (retire_cnt !== 64'd0) $display("FAIL rst_retire_cnt: got %0d want 0", retire_cnt); else passed++;
    total++; if (log_entry !== 67'd0) $display("FAIL rst_log_entry: got %h want 0", log_entry); else passed++;
  endtask

  task automatic test_clean_stream();
    do_reset();
    for (int n = 0; n < 10; n++) retire(64'(n), 32'h80 + 32'(4 * n), 32'h84 + 32'(4 * n), '0, '0, 1'b0);
    total++; if (retire_cnt !== 64'd10) $display("FAIL clean_retire_cnt: got %0d want 10", retire_cnt); else passed++;
    total++; if (err_mask !== 5'h00) $display("FAIL clean_err_mask: got %b want 00000", err_mask); else passed++;
    cyc(1);
    total++; if (log_valid !== 1'b0) $display("FAIL clean_log_valid: got %b want 0", log_valid); else passed++;
  endtask

  task automatic test_order_gap();
    rvfi_mon_log_t exp;
    do_reset();
    retire(64'd0, 32'h80, 32'h84, '0, '0, 1'b0);
    retire(64'd1, 32'h84, 32'h88, '0, '0, 1'b0);
    retire(64'd3, 32'h88, 32'h8C, '0, '0, 1'b0);
    total++; if (err_mask !== 5'b00001) $display("FAIL gap_err_mask: got %b want 00001", err_mask); else passed++;
    cyc(1);
    exp = '{3'd1, 32'h3, 32'h88};
    total++; if (log_valid !== 1'b1) $display("FAIL gap_log_valid: got %b want 1", log_valid); else passed++;
    total++; if (log_entry !== exp) $display("FAIL gap_entry: got %h want %h", log_entry, exp); else passed++;
    pop_one();
    total++; if (log_valid !== 1'b0) $display("FAIL gap_drained: got %b want 0", log_valid); else passed++;
  endtask

  task automatic test_pc_intr();
    rvfi_mon_log_t exp;
    do_reset();
    retire(64'd0, 32'hFC, 32'h100, '0, '0, 1'b0);
    retire(64'd1, 32'h104, 32'h108, '0, '0, 1'b0);
    total++; if (err_mask !== 5'b00010) $display("FAIL pc_err_mask: got %b want 00010", err_mask); else passed++;
    cyc(1);
    exp = '{3'd2, 32'h1, 32'h104};
    total++; if (log_entry !== exp) $display("FAIL pc_entry: got %h want %h", log_entry, exp); else passed++;
    pop_one();
    retire(64'd2, 32'h200, 32'h204, '0, INTR_EXC, 1'b0);
    total++; if (err_mask !== 5'b00010) $display("FAIL intr_err_mask: got %b want 00010", err_mask); else passed++;
    total++; if (intr_cnt !== 32'd1) $display("FAIL intr_cnt: got %0d want 1", intr_cnt); else passed++;
    cyc(1);
    total++; if (log_valid !== 1'b0) $display("FAIL intr_no_log: got %b want 0", log_valid); else passed++;
  endtask

  task automatic test_multi_error();
    rvfi_mon_log_t exp;
    do_reset();
    retire(64'd0, 32'h80, 32'h84, '0, '0, 1'b0);
    retire(64'd2, 32'h84, 32'h88, TRAP_BARE, '0, 1'b0);
    total++; if (err_mask !== 5'b01001) $display("FAIL multi_err_mask: got %b want 01001", err_mask); else passed++;
    total++; if (trap_cnt !== 32'd1) $display("FAIL multi_trap_cnt: got %0d want 1", trap_cnt); else passed++;
    cyc(1);
    exp = '{3'd1, 32'h2, 32'h84};
    total++; if (log_entry !== exp) $display("FAIL multi_entry: got %h want %h", log_entry, exp); else passed++;
    pop_one();
    total++; if (log_valid !== 1'b0) $display("FAIL multi_one_entry: got %b want 0", log_valid); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    retire(64'd0, 32'h80, 32'h84, '0, '0, 1'b0);
    for (int k = 1; k <= 6; k++) retire(64'(2 * k), 32'h80 + 32'(4 * k), 32'h84 + 32'(4 * k), '0, '0, 1'b0);
    cyc(2);
    total++; if (log_ovfl !== 1'b1) $display("FAIL ovfl_flag: got %b want 1", log_ovfl); else passed++;
    for (int k = 1; k <= 4; k++) begin
      total++; if (log_valid !== 1'b1 || log_entry.code !== 3'd1 || log_entry.order !== 32'(2 * k))
        $display("FAIL ovfl_drain%0d: got v=%b code=%0d order=%0d want v=1 code=1 order=%0d",
                 k, log_valid, log_entry.code, log_entry.order, 2 * k);
      else passed++;
      pop_one();
    end
    total++; if (log_valid !== 1'b0) $display("FAIL ovfl_empty: got %b want 0", log_valid); else passed++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    retire(64'd0, 32'h80, 32'h84, '0, '0, 1'b0);
    for (int k = 1; k <= 4; k++) retire(64'(2 * k), 32'h80 + 32'(4 * k), 32'h84 + 32'(4 * k), '0, '0, 1'b0);
    cyc(2);
    retire(64'd10, 32'h94, 32'h98, '0, '0, 1'b0);
    pop_one();
    total++; if (log_ovfl !== 1'b0) $display("FAIL fpp_ovfl: got %b want 0", log_ovfl); else passed++;
    for (int k = 2; k <= 5; k++) begin
      total++; if (log_valid !== 1'b1 || log_entry.order !== 32'(2 * k))
        $display("FAIL fpp_drain%0d: got v=%b order=%0d want v=1 order=%0d", k, log_valid, log_entry.order, 2 * k);
      else passed++;
      pop_one();
    end
    total++; if (log_valid !== 1'b0) $display("FAIL fpp_empty: got %b want 0", log_valid); else passed++;
  endtask

  task automatic test_halt_and_reset();
    rvfi_mon_log_t exp;
    do_reset();
    for (int n = 0; n < 5; n++) retire(64'(n), 32'h80 + 32'(4 * n), 32'h84 + 32'(4 * n), '0, '0, 1'b0);
    retire(64'd5, 32'h94, 32'h98, '0, '0, 1'b1);
    total++; if (err_mask !== 5'b00000) $display("FAIL halt_clean: got %b want 00000", err_mask); else passed++;
    retire(64'd6, 32'h98, 32'h9C, '0, '0, 1'b0);
    total++; if (err_mask !== 5'b10000) $display("FAIL halt_err_mask: got %b want 10000", err_mask); else passed++;
    cyc(1);
    exp = '{3'd5, 32'h6, 32'h98};
    total++; if (log_entry !== exp) $display("FAIL halt_entry: got %h want %h", log_entry, exp); else passed++;
    retire(64'd7, 32'h9C, 32'hA0, '0, '0, 1'b0);
    retire(64'd8, 32'hA0, 32'hA4, '0, '0, 1'b0);
    cyc(2);
    log_ready = 1'b1;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; log_ready = 1'b0;
    total++; if ({log_valid, log_ovfl, err_mask} !== 7'd0 || retire_cnt !== 64'd0 || trap_cnt !== 32'd0
                 || intr_cnt !== 32'd0 || log_entry !== 67'd0)
      $display("FAIL midrst_outputs: got v=%b ovfl=%b mask=%b ret=%0d trap=%0d intr=%0d entry=%h want all 0",
               log_valid, log_ovfl, err_mask, retire_cnt, trap_cnt, intr_cnt, log_entry);
    else passed++;
    retire(64'd100, 32'h400, 32'h404, '0, '0, 1'b0);
    total++; if (err_mask !== 5'b00000) $display("FAIL reseed_mask: got %b want 00000", err_mask); else passed++;
    total++; if (retire_cnt !== 64'd1) $display("FAIL reseed_cnt: got %0d want 1", retire_cnt); else passed++;
    retire(64'd101, 32'h404, 32'h408, '0, '0, 1'b0);
    cyc(1);
    total++; if (err_mask !== 5'b00000 || log_valid !== 1'b0)
      $display("FAIL reseed_track: got mask=%b v=%b want 00000 0", err_mask, log_valid);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_clean_stream();
    test_order_gap();
    test_pc_intr();
    test_multi_error();
    test_overflow();
    test_full_push_pop();
    test_halt_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
